// File: rtl/edit_mem_buf_pool_if.sv
// Request/grant and free-return bundle between the buffer pool and its clients.
interface edit_mem_buf_pool_if #(
  parameter int BPTR_NBITS = 10
) ();
  logic                  pu_buf_req;
  logic                  pu_buf_valid;
  logic [BPTR_NBITS-1:0] pu_buf_ptr;
  logic                  pu_buf_available;
  logic                  buf_free_valid;
  logic [BPTR_NBITS-1:0] buf_free_ptr;

  modport master (
    output pu_buf_req, buf_free_valid, buf_free_ptr,
    input  pu_buf_valid, pu_buf_ptr, pu_buf_available
  );

  modport slave (
    input  pu_buf_req, buf_free_valid, buf_free_ptr,
    output pu_buf_valid, pu_buf_ptr, pu_buf_available
  );
endinterface

// File: rtl/edit_mem_buf_pool.sv
// Free-buffer pool: circular free list of edit-memory buffer pointers,
// self-populated after reset, granting with fixed latency 1 and reclaiming frees.
module edit_mem_buf_pool #(
  parameter int BPTR_NBITS = 10,
  parameter int NUM_BUFS   = 1024,
  parameter int CNT_NBITS  = BPTR_NBITS + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  edit_mem_buf_pool_if.slave   bus,
  output logic [CNT_NBITS-1:0] free_count_o,
  output logic                 init_done_o,
  output logic                 overflow_err_o
);

  // state   | meaning
  // ST_INIT | writing pointers 0..NUM_BUFS-1 into the free list
  // ST_RUN  | serving grants and accepting frees
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [BPTR_NBITS-1:0] ram [NUM_BUFS];
  logic [BPTR_NBITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [BPTR_NBITS-1:0] init_ptr_q, init_ptr_d;
  logic [CNT_NBITS-1:0]  cnt_q, cnt_d;
  logic [BPTR_NBITS-1:0] ptr_q, ptr_d;
  logic                  valid_q, valid_d, avail_q, avail_d, ovf_q, ovf_d;

  logic                  grant, free_ok, free_drop, wr_en, init_last;
  logic [BPTR_NBITS-1:0] wr_data;

  function automatic logic [BPTR_NBITS-1:0] wrap_inc(input logic [BPTR_NBITS-1:0] idx);
    return (idx == BPTR_NBITS'(NUM_BUFS - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign init_last = (init_ptr_q == BPTR_NBITS'(NUM_BUFS - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (init_last) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Grant/free decisions use registered count only, so a same-cycle free never feeds a grant.
  always_comb begin
    init_done_o = (state_q == ST_RUN);
    grant       = bus.pu_buf_req && (state_q == ST_RUN) && (cnt_q != '0);
    free_ok     = bus.buf_free_valid && (state_q == ST_RUN) &&
                  (cnt_q != CNT_NBITS'(NUM_BUFS));
    free_drop   = bus.buf_free_valid && !free_ok;
    wr_en       = (state_q == ST_INIT) || free_ok;
    wr_data     = (state_q == ST_INIT) ? init_ptr_q : bus.buf_free_ptr;
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    init_ptr_d = init_ptr_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    valid_d    = bus.pu_buf_req;
    avail_d    = grant;
    ovf_d      = ovf_q || free_drop;
    if (state_q == ST_INIT) begin
      tail_d     = wrap_inc(tail_q);
      init_ptr_d = init_ptr_q + 1'b1;
      cnt_d      = cnt_q + 1'b1;
    end else begin
      if (grant) begin
        ptr_d  = ram[head_q];
        head_d = wrap_inc(head_q);
      end
      if (free_ok) tail_d = wrap_inc(tail_q);
      case ({free_ok, grant})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      init_ptr_q <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      valid_q    <= 1'b0;
      avail_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      init_ptr_q <= init_ptr_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      valid_q    <= valid_d;
      avail_q    <= avail_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) ram[tail_q] <= wr_data;
  end

  assign bus.pu_buf_valid     = valid_q;
  assign bus.pu_buf_available = avail_q;
  assign bus.pu_buf_ptr       = ptr_q;
  assign free_count_o         = cnt_q;
  assign overflow_err_o       = ovf_q;

endmodule

// File: tb/tb_edit_mem_buf_pool.sv
// Directed bench for edit_mem_buf_pool with a 16-entry pool and 5-bit pointers.
module tb_edit_mem_buf_pool;

  localparam int BPTR = 5;
  localparam int NBUF = 16;
  localparam int CNTW = BPTR + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CNTW-1:0] free_count;
  logic            init_done, overflow_err;

  edit_mem_buf_pool_if #(.BPTR_NBITS(BPTR)) bus ();

  edit_mem_buf_pool #(.BPTR_NBITS(BPTR), .NUM_BUFS(NBUF), .CNT_NBITS(CNTW)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .free_count_o   (free_count),
    .init_done_o    (init_done),
    .overflow_err_o (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            req;
    logic            fv;
    logic [BPTR-1:0] fp;
    logic            ev;
    logic            ea;
    logic [BPTR-1:0] ep;
    logic [CNTW-1:0] ec;
    logic            eo;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(int req, int fv, int fp, int ev, int ea, int ep, int ec, int eo);
    vec_t v;
    v.req = 1'(req); v.fv = 1'(fv); v.fp = BPTR'(fp);
    v.ev  = 1'(ev);  v.ea = 1'(ea); v.ep = BPTR'(ep);
    v.ec  = CNTW'(ec); v.eo = 1'(eo);
    tv.push_back(v);
  endfunction

  task automatic cyc(input logic req, input logic fv, input logic [BPTR-1:0] fp);
    bus.pu_buf_req     = req;
    bus.buf_free_valid = fv;
    bus.buf_free_ptr   = fp;
    @(posedge clk);
    #1;
    bus.pu_buf_req     = 1'b0;
    bus.buf_free_valid = 1'b0;
  endtask

  task automatic chk(input string name, input logic ev, input logic ea, input logic [BPTR-1:0] ep,
                     input logic [CNTW-1:0] ec, input logic ei, input logic eo);
    n_vec++;
    if (bus.pu_buf_valid !== ev || bus.pu_buf_available !== ea || bus.pu_buf_ptr !== ep ||
        free_count !== ec || init_done !== ei || overflow_err !== eo) begin
      n_err++;
      $display("FAIL %s: got v=%b a=%b p=%0d cnt=%0d init=%b ovf=%b, want v=%b a=%b p=%0d cnt=%0d init=%b ovf=%b",
               name, bus.pu_buf_valid, bus.pu_buf_available, bus.pu_buf_ptr, free_count,
               init_done, overflow_err, ev, ea, ep, ec, ei, eo);
    end
  endtask

  initial begin
    // Table covers RUN-mode traffic starting right after the first init.
    add(1,0,0,  1,1,0,15,0);
    add(1,0,0,  1,1,1,14,0);
    add(1,0,0,  1,1,2,13,0);
    add(0,0,0,  0,0,2,13,0);
    for (int i = 3; i < NBUF; i++) add(1,0,0, 1,1,i,15-i,0);
    add(1,0,0,  1,0,15,0,0);
    add(0,1,5,  0,0,15,1,0);
    add(1,0,0,  1,1,5,0,0);
    add(1,1,9,  1,0,5,1,0);
    add(1,0,0,  1,1,9,0,0);
    add(0,1,7,  0,0,9,1,0);
    add(1,1,11, 1,1,7,1,0);
    add(1,0,0,  1,1,11,0,0);
    for (int i = 0; i < NBUF; i++) add(0,1,15-i, 0,0,11,i+1,0);
    add(0,1,3,  0,0,11,16,1);
    add(0,0,0,  0,0,11,16,1);
    add(1,0,0,  1,1,15,15,1);
    add(0,1,3,  0,0,15,16,1);

    bus.pu_buf_req     = 1'b0;
    bus.buf_free_valid = 1'b0;
    bus.buf_free_ptr   = '0;

    rst = 1'b1;
    cyc(0, 0, 0);
    chk("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Cycle k writes pointer k; a request in cycle 3 is refused.
    for (int k = 0; k < NBUF; k++) begin
      cyc(k == 3, 0, 0);
      chk($sformatf("init_c%0d", k + 1), k == 3, 0, 0, CNTW'(k + 1), k + 1 == NBUF, 0);
    end

    foreach (tv[i]) begin
      cyc(tv[i].req, tv[i].fv, tv[i].fp);
      chk($sformatf("vec%0d", i), tv[i].ev, tv[i].ea, tv[i].ep, tv[i].ec, 1'b1, tv[i].eo);
    end

    rst = 1'b1;
    cyc(0, 0, 0);
    chk("rerst", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < NBUF - 1; k++) cyc(0, 0, 0);
    chk("reinit_c15", 0, 0, 0, 15, 0, 0);
    cyc(0, 0, 0);
    chk("reinit_c16", 0, 0, 0, 16, 1, 0);
    cyc(1, 0, 0);
    chk("reinit_grant0", 1, 1, 0, 15, 1, 0);

    rst = 1'b1;
    cyc(0, 0, 0);
    rst = 1'b0;
    cyc(0, 1, 7);
    chk("init_free_drop", 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0);
    chk("init_ovf_sticky", 0, 0, 0, 2, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
